// File: rtl/sdr_burst_wr.sv
// Single-bank SDRAM burst-write sequencer: ACTIVE, WRITE burst, tWR, then PRECHARGE or auto-precharge.
// Pad-side outputs are registered; wr_data_rd is a combinational pop strobe for an upstream FWFT FIFO.
module sdr_burst_wr #(
  parameter int unsigned DQ_W      = 16,
  parameter int unsigned BA_W      = 2,
  parameter int unsigned ROW_W     = 13,
  parameter int unsigned COL_W     = 9,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned NRCD      = 3,
  parameter int unsigned NWR       = 2,
  parameter int unsigned NRP       = 3,
  parameter int unsigned AUTO_PRE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [BA_W-1:0]   wr_bank,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic [DQ_W/8-1:0] wr_be,
  output logic              wr_data_rd,
  output logic              wr_busy,
  output logic              wr_done,
  output logic              sdr_CKE,
  output logic              sdr_nCS,
  output logic [BA_W-1:0]   sdr_BA,
  output logic [ROW_W-1:0]  sdr_A,
  output logic              sdr_nRAS,
  output logic              sdr_nCAS,
  output logic              sdr_nWE,
  output logic [DQ_W-1:0]   sdr_DQ_o,
  output logic              sdr_DQ_oe,
  output logic [DQ_W/8-1:0] sdr_DQM
);
  localparam int unsigned BeW    = DQ_W / 8;
  localparam int unsigned TwrRp  = NWR + NRP;
  localparam int unsigned MaxA   = (NRCD > TwrRp) ? NRCD : TwrRp;
  localparam int unsigned CntMax = (MaxA > BURST_LEN) ? MaxA : BURST_LEN;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RcdLd   = CntW'(NRCD - 1);
  localparam logic [CntW-1:0] BurstLd = CntW'(BURST_LEN - 1);
  localparam logic [CntW-1:0] TwrLd   = CntW'((NWR > 1) ? NWR - 2 : 0);
  localparam logic [CntW-1:0] RpLd    = CntW'(NRP - 1);

  localparam logic [2:0] CmdNop   = 3'b111;
  localparam logic [2:0] CmdAct   = 3'b011;
  localparam logic [2:0] CmdWrite = 3'b100;
  localparam logic [2:0] CmdPre   = 3'b010;

  typedef enum logic [2:0] {StIdle, StAct, StWr, StTwr, StPre} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [BA_W-1:0]  ba_q, ba_d;
  logic [ROW_W-1:0] a_q, a_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DQ_W-1:0]  dq_q, dq_d;
  logic             oe_q, oe_d;
  logic [BeW-1:0]   dqm_q, dqm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             go_pre;
  logic [ROW_W-1:0] wr_addr;

  // WRITE address: column zero-extended, A10 selects auto-precharge.
  always_comb begin
    wr_addr                = '0;
    wr_addr[COL_W-1:0]     = col_q;
    wr_addr[10]            = (AUTO_PRE != 0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = CmdNop;
    ba_d       = ba_q;
    a_d        = a_q;
    col_d      = col_q;
    dq_d       = dq_q;
    oe_d       = 1'b0;
    dqm_d      = '1;
    busy_d     = busy_q;
    done_d     = 1'b0;
    go_pre     = 1'b0;
    wr_data_rd = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A request coinciding with the wr_done pulse is dropped.
        if (wr_req && !done_q) begin
          state_d = StAct;
          cnt_d   = RcdLd;
          cmd_d   = CmdAct;
          ba_d    = wr_bank;
          a_d     = wr_row;
          col_d   = wr_col;
          busy_d  = 1'b1;
        end
      end
      StAct: begin
        if (cnt_q == '0) begin
          wr_data_rd = 1'b1;
          state_d    = StWr;
          cnt_d      = BurstLd;
          cmd_d      = CmdWrite;
          a_d        = wr_addr;
          dq_d       = wr_data;
          oe_d       = 1'b1;
          dqm_d      = ~wr_be;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWr: begin
        if (cnt_q != '0) begin
          wr_data_rd = 1'b1;
          cnt_d      = cnt_q - 1'b1;
          dq_d       = wr_data;
          oe_d       = 1'b1;
          dqm_d      = ~wr_be;
        end else if (NWR == 1) begin
          go_pre = 1'b1;
        end else begin
          state_d = StTwr;
          cnt_d   = TwrLd;
        end
      end
      StTwr: begin
        if (cnt_q == '0) begin
          go_pre = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // The tRP window is timed the same way with or without an explicit PRECHARGE.
    if (go_pre) begin
      state_d = StPre;
      cnt_d   = RpLd;
      if (AUTO_PRE == 0) begin
        cmd_d = CmdPre;
        a_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= CmdNop;
      ba_q    <= '0;
      a_q     <= '0;
      col_q   <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      dqm_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
      col_q   <= col_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      dqm_q   <= dqm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_busy   = busy_q;
  assign wr_done   = done_q;
  assign sdr_CKE   = 1'b1;
  assign sdr_nCS   = ~busy_q;
  assign sdr_BA    = ba_q;
  assign sdr_A     = a_q;
  assign sdr_nRAS  = cmd_q[2];
  assign sdr_nCAS  = cmd_q[1];
  assign sdr_nWE   = cmd_q[0];
  assign sdr_DQ_o  = dq_q;
  assign sdr_DQ_oe = oe_q;
  assign sdr_DQM   = dqm_q;

endmodule

// File: tb/tb_sdr_burst_wr.sv
// Bench for sdr_burst_wr: four parameterisations, directed vector table, hand sequences and
// randomized transactions checked cycle by cycle against a timeline model.
module tb_sdr_burst_wr;
  localparam int NCFG = 4;
  localparam logic [2:0] CNop = 3'b111;
  localparam logic [2:0] CAct = 3'b011;
  localparam logic [2:0] CWr  = 3'b100;
  localparam logic [2:0] CPre = 3'b010;

  function automatic int cfg_bl(input int g);
    if (g == 2) return 1;
    if (g == 3) return 8;
    return 4;
  endfunction
  function automatic int cfg_rcd(input int g);
    return (g >= 2) ? 2 : 3;
  endfunction
  function automatic int cfg_wr(input int g);
    return (g >= 2) ? 1 : 2;
  endfunction
  function automatic int cfg_rp(input int g);
    return (g >= 2) ? 2 : 3;
  endfunction
  function automatic int cfg_ap(input int g);
    return (g == 1) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic [NCFG-1:0]       req, rd, busy, done, cke, ncs, nras, ncas, nwe, oe;
  logic [NCFG-1:0][1:0]  bank, wbe, sba, dqm;
  logic [NCFG-1:0][12:0] row, sa;
  logic [NCFG-1:0][8:0]  col;
  logic [NCFG-1:0][15:0] wdata, dq, hold_dq;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    sdr_burst_wr #(
      .BURST_LEN(cfg_bl(g)),
      .NRCD     (cfg_rcd(g)),
      .NWR      (cfg_wr(g)),
      .NRP      (cfg_rp(g)),
      .AUTO_PRE (cfg_ap(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .wr_req    (req[g]),
      .wr_bank   (bank[g]),
      .wr_row    (row[g]),
      .wr_col    (col[g]),
      .wr_data   (wdata[g]),
      .wr_be     (wbe[g]),
      .wr_data_rd(rd[g]),
      .wr_busy   (busy[g]),
      .wr_done   (done[g]),
      .sdr_CKE   (cke[g]),
      .sdr_nCS   (ncs[g]),
      .sdr_BA    (sba[g]),
      .sdr_A     (sa[g]),
      .sdr_nRAS  (nras[g]),
      .sdr_nCAS  (ncas[g]),
      .sdr_nWE   (nwe[g]),
      .sdr_DQ_o  (dq[g]),
      .sdr_DQ_oe (oe[g]),
      .sdr_DQM   (dqm[g])
    );
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cur_g = 0;
  logic [15:0] beat_v [8];
  logic [1:0]  be_v   [8];

  typedef struct {
    int          acts;
    int          wr_cyc;
    logic [12:0] wr_a;
    int          pre_cyc;
    int          done_cyc;
    int          rd_first;
    int          rd_cnt;
  } txn_obs_t;

  typedef struct {
    int          g;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic [1:0]  be2;
    int          extra_req;
    int          rst_at;
    int          exp_acts;
    int          exp_wr_cyc;
    logic [12:0] exp_wr_a;
    int          exp_pre_cyc;
    int          exp_done_cyc;
    int          exp_rd_first;
    int          exp_rd_cnt;
  } vec_t;

  txn_obs_t obs;
  vec_t     vecs [8];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s cyc%0d: got 0x%0h, want 0x%0h", cur_g, nm, c, act, exp);
    end
  endtask

  // Cycle c counts from the edge that samples wr_req (edge 0); outputs sampled on negedge.
  task automatic run_txn(input int g, input logic [1:0] b, input logic [12:0] r,
                         input logic [8:0] cl, input int extra_req, input int rst_at,
                         input bit hold_req, output txn_obs_t o);
    int bl, rcd, nwr, nrp, lst, dn, ptr, k;
    bit pop, ab, e_oe, e_busy, e_done, e_rd;
    logic [2:0]  e_cmd, cmd;
    logic [15:0] e_dq;
    logic [1:0]  e_dqm;
    logic [12:0] wa;
    bl = cfg_bl(g); rcd = cfg_rcd(g); nwr = cfg_wr(g); nrp = cfg_rp(g);
    lst = rcd + bl;
    dn  = lst + nwr + nrp;
    o.acts = 0; o.wr_cyc = 0; o.wr_a = '0; o.pre_cyc = 0; o.done_cyc = 0;
    o.rd_first = 0; o.rd_cnt = 0;
    wa = '0;
    wa[8:0] = cl;
    wa[10]  = (cfg_ap(g) != 0);
    ptr = 0; pop = 1'b0; e_dq = hold_dq[g];
    @(negedge clk);
    req[g] = 1'b1; bank[g] = b; row[g] = r; col[g] = cl;
    wdata[g] = beat_v[0]; wbe[g] = be_v[0];
    for (int c = 1; c <= dn + 1; c++) begin
      @(negedge clk);
      if (pop && ptr < 7) ptr++;
      wdata[g] = beat_v[ptr]; wbe[g] = be_v[ptr];
      if (!hold_req) req[g] = (c == extra_req);
      rst = (rst_at != 0) && (c == rst_at);
      ab  = (rst_at != 0) && (c > rst_at);
      e_cmd = CNop;
      if (!ab) begin
        if (c == 1) e_cmd = CAct;
        else if (c == 1 + rcd) e_cmd = CWr;
        else if (cfg_ap(g) == 0 && c == lst + nwr) e_cmd = CPre;
      end
      e_oe  = !ab && c >= 1 + rcd && c <= lst;
      e_dqm = 2'b11;
      if (ab) e_dq = 16'h0;
      else if (e_oe) begin
        k = c - 1 - rcd;
        e_dq  = beat_v[k];
        e_dqm = ~be_v[k];
      end
      e_busy = !ab && c < dn;
      e_done = !ab && c == dn;
      e_rd   = !ab && c >= rcd && c < rcd + bl;
      cmd = {nras[g], ncas[g], nwe[g]};
      chk("cmd", c, cmd, e_cmd);
      chk("busy", c, busy[g], e_busy);
      chk("done", c, done[g], e_done);
      chk("ncs", c, ncs[g], !e_busy);
      chk("cke", c, cke[g], 1'b1);
      chk("dq_oe", c, oe[g], e_oe);
      chk("dq", c, dq[g], e_dq);
      chk("dqm", c, dqm[g], e_dqm);
      chk("data_rd", c, rd[g], e_rd);
      if (e_cmd != CNop) chk("ba", c, sba[g], b);
      if (e_cmd == CAct) chk("a_row", c, sa[g], r);
      if (e_cmd == CWr)  chk("a_col", c, sa[g], wa);
      if (e_cmd == CPre) chk("a10_pre", c, sa[g][10], 1'b0);
      if (cmd == CAct) o.acts++;
      if (cmd == CWr && o.wr_cyc == 0) begin o.wr_cyc = c; o.wr_a = sa[g]; end
      if (cmd == CPre && o.pre_cyc == 0) o.pre_cyc = c;
      if (done[g] && o.done_cyc == 0) o.done_cyc = c;
      if (rd[g]) begin
        if (o.rd_cnt == 0) o.rd_first = c;
        o.rd_cnt++;
      end
      pop = rd[g];
    end
    rst = 1'b0;
    hold_dq[g] = e_dq;
    if (rst_at != 0) hold_dq = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    // {g, bank, row, col, be2, extra_req, rst_at, acts, wr_cyc, wr_a, pre, done, rd_first, rd_cnt}
    vecs[0] = '{0, 2'd2, 13'h1A5, 9'h010, 2'b11, 0, 0, 1, 4, 13'h010, 9, 12, 3, 4};
    vecs[1] = '{1, 2'd2, 13'h1A5, 9'h010, 2'b11, 0, 0, 1, 4, 13'h410, 0, 12, 3, 4};
    vecs[2] = '{0, 2'd2, 13'h1A5, 9'h010, 2'b01, 0, 0, 1, 4, 13'h010, 9, 12, 3, 4};
    vecs[3] = '{0, 2'd2, 13'h1A5, 9'h010, 2'b11, 5, 0, 1, 4, 13'h010, 9, 12, 3, 4};
    vecs[4] = '{0, 2'd2, 13'h1A5, 9'h010, 2'b11, 0, 5, 1, 4, 13'h010, 0, 0, 3, 3};
    vecs[5] = '{0, 2'd1, 13'h0FF, 9'h1F0, 2'b10, 0, 0, 1, 4, 13'h1F0, 9, 12, 3, 4};
    vecs[6] = '{2, 2'd3, 13'h123, 9'h0AB, 2'b11, 0, 0, 1, 3, 13'h0AB, 4, 6, 2, 1};
    vecs[7] = '{3, 2'd0, 13'h1FFF, 9'h1FF, 2'b00, 0, 0, 1, 3, 13'h1FF, 11, 13, 2, 8};

    rst = 1'b1;
    req = '0; bank = '0; row = '0; col = '0; wdata = '0; wbe = '0; hold_dq = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      cur_g = g;
      chk("rst_cmd", 0, {nras[g], ncas[g], nwe[g]}, CNop);
      chk("rst_ncs", 0, ncs[g], 1'b1);
      chk("rst_a", 0, sa[g], 13'h0);
      chk("rst_ba", 0, sba[g], 2'h0);
      chk("rst_dq", 0, dq[g], 16'h0);
      chk("rst_oe", 0, oe[g], 1'b0);
      chk("rst_dqm", 0, dqm[g], 2'b11);
      chk("rst_busy", 0, busy[g], 1'b0);
      chk("rst_done", 0, done[g], 1'b0);
      chk("rst_rd", 0, rd[g], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      cur_g = vecs[i].g;
      for (int k = 0; k < 8; k++) begin
        beat_v[k] = 16'(16'hA000 + k);
        be_v[k]   = 2'b11;
      end
      be_v[2] = vecs[i].be2;
      run_txn(vecs[i].g, vecs[i].bank, vecs[i].row, vecs[i].col, vecs[i].extra_req,
              vecs[i].rst_at, 1'b0, obs);
      chk("n_active", i, obs.acts, vecs[i].exp_acts);
      chk("write_cyc", i, obs.wr_cyc, vecs[i].exp_wr_cyc);
      chk("write_addr", i, obs.wr_a, vecs[i].exp_wr_a);
      chk("pre_cyc", i, obs.pre_cyc, vecs[i].exp_pre_cyc);
      chk("done_cyc", i, obs.done_cyc, vecs[i].exp_done_cyc);
      chk("rd_first", i, obs.rd_first, vecs[i].exp_rd_first);
      chk("rd_count", i, obs.rd_cnt, vecs[i].exp_rd_cnt);
    end

    // wr_req held high: ignored in the done cycle, restarts after one IDLE cycle.
    cur_g = 2;
    for (int k = 0; k < 8; k++) begin beat_v[k] = 16'(16'h3C00 + k); be_v[k] = 2'b11; end
    run_txn(2, 2'd3, 13'h0AA, 9'h055, 0, 0, 1'b1, obs);
    chk("hold_done_cyc", 0, obs.done_cyc, 6);
    @(negedge clk);
    chk("hold_restart_act", 0, {nras[2], ncas[2], nwe[2]}, CAct);
    chk("hold_restart_busy", 0, busy[2], 1'b1);
    req[2] = 1'b0; wdata[2] = 16'h5A5A; wbe[2] = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (done[2]) found = 1'b1;
    end
    chk("hold_drain_done", 0, found, 1'b1);
    hold_dq[2] = 16'h5A5A;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      int ex;
      cur_g = $urandom_range(0, NCFG - 1);
      for (int k = 0; k < 8; k++) begin
        beat_v[k] = 16'($urandom);
        be_v[k]   = 2'($urandom);
      end
      ex = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6)) : 0;
      run_txn(cur_g, 2'($urandom), 13'($urandom), 9'($urandom), ex, 0, 1'b0, obs);
      chk("rnd_n_active", i, obs.acts, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
